// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: address sizing, reset vector and the
// next-PC source encoding used by the fetch-address generator.
package cpu_pkg;

   localparam int ADDR_WIDTH  = 10;
   localparam int INSTR_WIDTH = 12;

   localparam logic [ADDR_WIDTH-1:0] RESET_PC = '0;

   typedef enum logic [2:0] {
      PC_HOLD,
      PC_INC,
      PC_BRANCH,
      PC_JUMP,
      PC_CALL,
      PC_RET
   } pc_src_e;

endpackage

// File: rtl/program_counter_if.sv
// Control/status bundle between decode/execute (master) and the
// fetch-address generator (slave).
interface program_counter_if #(
   parameter int ADDR_WIDTH   = 10,
   parameter int OFFSET_WIDTH = 8,
   parameter int DEPTH_WIDTH  = 3
);

   logic                    stall;
   logic                    branch_taken;
   logic [OFFSET_WIDTH-1:0] branch_offset;
   logic                    jump;
   logic                    call;
   logic                    ret;
   logic [ADDR_WIDTH-1:0]   jump_addr;
   logic [ADDR_WIDTH-1:0]   instruction_addr_pc;
   logic [DEPTH_WIDTH-1:0]  stack_depth;
   logic                    stack_overflow;
   logic                    stack_underflow;

   // Level-sampled controls: no handshake, every control is consumed on each
   // rising edge and the registered status reflects the result after it.
   modport master (
      output stall, branch_taken, branch_offset, jump, call, ret, jump_addr,
      input  instruction_addr_pc, stack_depth, stack_overflow, stack_underflow
   );

   modport slave (
      input  stall, branch_taken, branch_offset, jump, call, ret, jump_addr,
      output instruction_addr_pc, stack_depth, stack_overflow, stack_underflow
   );

endinterface

// File: rtl/program_counter_return_stack.sv
// Return-address LIFO. Callers must never push while full or pop while empty;
// no overflow/underflow protection is done here.
module return_stack #(
   parameter int DEPTH       = 4,
   parameter int WIDTH       = 10,
   localparam int PTR_WIDTH  = $clog2(DEPTH),
   localparam int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic                 pop,
   input  logic [WIDTH-1:0]     push_data,
   output logic [WIDTH-1:0]     top,
   output logic [CNT_WIDTH-1:0] depth,
   output logic                 full,
   output logic                 empty
);

   logic [WIDTH-1:0]     mem [DEPTH];
   logic [CNT_WIDTH-1:0] top_idx;

   assign full    = (depth == CNT_WIDTH'(DEPTH));
   assign empty   = (depth == '0);
   assign top_idx = depth - CNT_WIDTH'(1);
   assign top     = mem[top_idx[PTR_WIDTH-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         depth <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[depth[PTR_WIDTH-1:0]] <= push_data;
         depth <= depth + CNT_WIDTH'(1);
      end else if (pop) begin
         depth <= depth - CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/program_counter.sv
// Fetch-address generator: increment, relative branch, absolute jump and
// call/return through a small hardware return stack, with stall hold.
module program_counter #(
   parameter int  ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
   parameter int  OFFSET_WIDTH = 8,
   parameter int  STACK_DEPTH  = 4,
   localparam int DEPTH_WIDTH  = $clog2(STACK_DEPTH) + 1
) (
   input logic              clk,
   input logic              reset_pc,
   program_counter_if.slave bus
);

   import cpu_pkg::*;

   pc_src_e                src;
   logic [ADDR_WIDTH-1:0]  pc;
   logic [ADDR_WIDTH-1:0]  pc_inc;
   logic [ADDR_WIDTH-1:0]  offset_ext;
   logic [ADDR_WIDTH-1:0]  next_pc;
   logic [ADDR_WIDTH-1:0]  stack_top;
   logic [DEPTH_WIDTH-1:0] depth;
   logic                   full;
   logic                   empty;
   logic                   push;
   logic                   pop;
   logic                   overflow;
   logic                   underflow;

   // Only the highest-priority asserted control is allowed to act.
   always_comb begin
      src = PC_INC;
      if (bus.stall)             src = PC_HOLD;
      else if (bus.ret)          src = PC_RET;
      else if (bus.call)         src = PC_CALL;
      else if (bus.jump)         src = PC_JUMP;
      else if (bus.branch_taken) src = PC_BRANCH;
   end

   assign pc_inc     = pc + ADDR_WIDTH'(1);
   assign offset_ext = {{(ADDR_WIDTH-OFFSET_WIDTH){bus.branch_offset[OFFSET_WIDTH-1]}},
                        bus.branch_offset};
   assign push       = (src == PC_CALL) && !full;
   assign pop        = (src == PC_RET) && !empty;

   always_comb begin
      next_pc = pc_inc;
      case (src)
         PC_HOLD:   next_pc = pc;
         PC_BRANCH: next_pc = pc + offset_ext;
         PC_JUMP:   next_pc = bus.jump_addr;
         PC_CALL:   next_pc = bus.jump_addr;
         // A return with nothing on the stack falls through to PC+1.
         PC_RET:    next_pc = empty ? pc_inc : stack_top;
         default:   next_pc = pc_inc;
      endcase
   end

   always_ff @(posedge clk or posedge reset_pc) begin
      if (reset_pc) begin
         pc        <= ADDR_WIDTH'(RESET_PC);
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         pc <= next_pc;
         if ((src == PC_CALL) && full)  overflow  <= 1'b1;
         if ((src == PC_RET) && empty)  underflow <= 1'b1;
      end
   end

   return_stack #(
      .DEPTH (STACK_DEPTH),
      .WIDTH (ADDR_WIDTH)
   ) u_return_stack (
      .clk       (clk),
      .rst       (reset_pc),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top       (stack_top),
      .depth     (depth),
      .full      (full),
      .empty     (empty)
   );

   assign bus.instruction_addr_pc = pc;
   assign bus.stack_depth         = depth;
   assign bus.stack_overflow      = overflow;
   assign bus.stack_underflow     = underflow;

endmodule

// File: tb/tb_program_counter.sv
// Directed and randomized bench for program_counter against an arithmetic
// reference model with a queue-based return stack.
module tb_program_counter;

   localparam int AW    = 10;
   localparam int OW    = 8;
   localparam int SD    = 4;
   localparam int DW    = 3;
   localparam int MOD   = 1 << AW;

   logic clk;
   logic reset_pc;

   int checks = 0;
   int errors = 0;

   int m_pc;
   int m_stack[$];
   bit m_ov;
   bit m_un;

   program_counter_if #(.ADDR_WIDTH(AW), .OFFSET_WIDTH(OW), .DEPTH_WIDTH(DW)) bus ();

   program_counter #(
      .ADDR_WIDTH   (AW),
      .OFFSET_WIDTH (OW),
      .STACK_DEPTH  (SD)
   ) dut (
      .clk      (clk),
      .reset_pc (reset_pc),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [AW+DW+1:0] model_vec();
      return {AW'(m_pc), DW'(m_stack.size()), m_ov, m_un};
   endfunction

   function automatic logic [AW+DW+1:0] dut_vec();
      return {bus.instruction_addr_pc, bus.stack_depth, bus.stack_overflow, bus.stack_underflow};
   endfunction

   task automatic model_reset();
      m_pc = 0;
      m_stack.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
   endtask

   task automatic model_step();
      int o;
      if (bus.stall) return;
      if (bus.ret) begin
         if (m_stack.size() > 0) m_pc = m_stack.pop_back();
         else begin
            m_pc = (m_pc + 1) % MOD;
            m_un = 1'b1;
         end
      end else if (bus.call) begin
         if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % MOD);
         else m_ov = 1'b1;
         m_pc = int'(bus.jump_addr);
      end else if (bus.jump) begin
         m_pc = int'(bus.jump_addr);
      end else if (bus.branch_taken) begin
         o = int'(bus.branch_offset);
         if (o >= (1 << (OW - 1))) o -= (1 << OW);
         m_pc = (m_pc + o + MOD) % MOD;
      end else begin
         m_pc = (m_pc + 1) % MOD;
      end
   endtask

   task automatic idle_inputs();
      bus.stall         = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_offset = '0;
      bus.jump          = 1'b0;
      bus.call          = 1'b0;
      bus.ret           = 1'b0;
      bus.jump_addr     = '0;
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_pc = 1'b1;
      idle_inputs();
      model_reset();
      @(posedge clk);
      #1;
      reset_pc = 1'b0;
   endtask

   task automatic test_reset();
      reset_pc = 1'b1;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (dut_vec() !== {AW'(0), DW'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got %h, expected %h", dut_vec(), {AW'(0), DW'(0), 2'b00});
      end
      reset_pc = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cycle();
         checks++;
         if (bus.instruction_addr_pc !== AW'(i) || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL free_run[%0d]: got pc=%0d, expected pc=%0d", i, bus.instruction_addr_pc, i);
         end
      end
      #1;
      reset_pc = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== {AW'(0), DW'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: got %h, expected %h", dut_vec(), {AW'(0), DW'(0), 2'b00});
      end
      @(posedge clk);
      #1;
      reset_pc = 1'b0;
   endtask

   task automatic test_wrap_branch();
      int exp_pc [4] = '{1022, 1023, 0, 1};
      do_reset();
      bus.jump = 1'b1;
      bus.jump_addr = AW'(1022);
      for (int i = 0; i < 4; i++) begin
         cycle();
         idle_inputs();
         checks++;
         if (bus.instruction_addr_pc !== AW'(exp_pc[i]) || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL wrap[%0d]: got pc=%0d, expected pc=%0d", i, bus.instruction_addr_pc, exp_pc[i]);
         end
      end
      bus.jump = 1'b1; bus.jump_addr = AW'(5);
      cycle();
      idle_inputs();
      bus.branch_taken = 1'b1; bus.branch_offset = 8'hF8;
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(1021) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL branch_neg: got pc=%0d, expected pc=1021", bus.instruction_addr_pc);
      end
      bus.jump = 1'b1; bus.jump_addr = AW'(10);
      cycle();
      idle_inputs();
      bus.branch_taken = 1'b1; bus.branch_offset = 8'h7F;
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(137) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL branch_pos: got pc=%0d, expected pc=137", bus.instruction_addr_pc);
      end
   endtask

   task automatic test_call_ret();
      do_reset();
      bus.jump = 1'b1; bus.jump_addr = AW'(3);
      cycle();
      idle_inputs();
      bus.call = 1'b1; bus.jump_addr = AW'(100);
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(100) || bus.stack_depth !== DW'(1) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL call: got pc=%0d depth=%0d, expected pc=100 depth=1", bus.instruction_addr_pc, bus.stack_depth);
      end
      cycle();
      bus.ret = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(4) || bus.stack_depth !== DW'(0) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL ret: got pc=%0d depth=%0d, expected pc=4 depth=0", bus.instruction_addr_pc, bus.stack_depth);
      end
      bus.call = 1'b1; bus.jump_addr = AW'(600);
      cycle();
      idle_inputs();
      bus.ret = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(5) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL back_to_back: got pc=%0d, expected pc=5", bus.instruction_addr_pc);
      end
   endtask

   task automatic test_overflow_underflow();
      int ret_pc [5] = '{31, 21, 11, 1, 2};
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         bus.call = 1'b1; bus.jump_addr = AW'(10 * i);
         cycle();
         idle_inputs();
         if (i < 5) begin
            bus.jump = 1'b1; bus.jump_addr = AW'(10 * i);
            cycle();
            idle_inputs();
         end
      end
      checks++;
      if (bus.instruction_addr_pc !== AW'(50) || bus.stack_depth !== DW'(4) ||
          bus.stack_overflow !== 1'b1 || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL overflow: got pc=%0d depth=%0d ov=%0b, expected pc=50 depth=4 ov=1",
                  bus.instruction_addr_pc, bus.stack_depth, bus.stack_overflow);
      end
      for (int i = 0; i < 5; i++) begin
         bus.ret = 1'b1;
         cycle();
         idle_inputs();
         checks++;
         if (bus.instruction_addr_pc !== AW'(ret_pc[i]) || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL ret_chain[%0d]: got %h, expected pc=%0d (model %h)", i, dut_vec(), ret_pc[i], model_vec());
         end
      end
      checks++;
      if (bus.stack_underflow !== 1'b1 || bus.stack_overflow !== 1'b1 || bus.stack_depth !== DW'(0)) begin
         errors++;
         $display("FAIL underflow: got un=%0b ov=%0b depth=%0d, expected un=1 ov=1 depth=0",
                  bus.stack_underflow, bus.stack_overflow, bus.stack_depth);
      end
   endtask

   task automatic test_stall_priority();
      do_reset();
      bus.call = 1'b1; bus.jump_addr = AW'(7);
      cycle();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         bus.stall = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.jump_addr = AW'(300);
         cycle();
         checks++;
         if (bus.instruction_addr_pc !== AW'(7) || bus.stack_depth !== DW'(1) || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL stall[%0d]: got pc=%0d depth=%0d, expected pc=7 depth=1", i, bus.instruction_addr_pc, bus.stack_depth);
         end
      end
      idle_inputs();
      bus.ret = 1'b1; bus.call = 1'b1; bus.jump = 1'b1; bus.jump_addr = AW'(400);
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(1) || bus.stack_depth !== DW'(0) || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL ret_priority: got pc=%0d depth=%0d, expected pc=1 depth=0", bus.instruction_addr_pc, bus.stack_depth);
      end
   endtask

   task automatic test_reset_mid_call();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         bus.call = 1'b1; bus.jump_addr = AW'(200 + i);
         cycle();
      end
      bus.jump_addr = AW'(900);
      #1;
      reset_pc = 1'b1;
      model_reset();
      #1;
      checks++;
      if (dut_vec() !== {AW'(0), DW'(0), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid_call: got %h, expected %h", dut_vec(), {AW'(0), DW'(0), 2'b00});
      end
      @(posedge clk);
      #1;
      reset_pc = 1'b0;
      idle_inputs();
      bus.ret = 1'b1;
      cycle();
      idle_inputs();
      checks++;
      if (bus.instruction_addr_pc !== AW'(1) || bus.stack_underflow !== 1'b1 || dut_vec() !== model_vec()) begin
         errors++;
         $display("FAIL post_reset_ret: got %h, expected %h", dut_vec(), model_vec());
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         if (i % 150 == 0) do_reset();
         bus.stall         = ($urandom_range(0, 9) == 0);
         bus.ret           = ($urandom_range(0, 4) == 0);
         bus.call          = ($urandom_range(0, 3) == 0);
         bus.jump          = ($urandom_range(0, 6) == 0);
         bus.branch_taken  = ($urandom_range(0, 2) == 0);
         bus.branch_offset = OW'($urandom);
         bus.jump_addr     = AW'($urandom_range(0, MOD - 1));
         cycle();
         checks++;
         if (dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL random[%0d]: got %h, expected %h", i, dut_vec(), model_vec());
         end
      end
      idle_inputs();
   endtask

   initial begin
      reset_pc = 1'b1;
      idle_inputs();
      model_reset();
      test_reset();
      test_wrap_branch();
      test_call_ret();
      test_overflow_underflow();
      test_stall_priority();
      test_reset_mid_call();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_counter.md
# program_counter

Fetch-address generator that drives `instruction_addr_pc` of the instruction memory each cycle. It supports sequential increment, PC-relative branch, absolute jump, and call/return through a small hardware return-address stack. Stall hold is provided for the downstream pipeline. It sits directly upstream of the instruction memory and takes its control inputs from the decode/execute logic.

## Interface
- `ADDR_WIDTH`, 10, width of the instruction address
- `OFFSET_WIDTH`, 8, width of the signed branch offset
- `STACK_DEPTH`, 4, return-stack entries (power of two, ≥2)
- `clk` in 1: single clock, all state updates on the rising edge
- `reset_pc` in 1: asynchronous, active-high reset
- `stall` in 1: hold the PC and stack; all other controls are ignored
- `branch_taken` in 1: PC ← PC + sign-extended `branch_offset`
- `branch_offset` in OFFSET_WIDTH: two's-complement offset relative to the current PC
- `jump` in 1: PC ← `jump_addr`
- `call` in 1: push PC+1, then PC ← `jump_addr`
- `ret` in 1: PC ← popped return address
- `jump_addr` in ADDR_WIDTH: absolute target for `jump` and `call`
- `instruction_addr_pc` out ADDR_WIDTH: current fetch address, registered
- `stack_depth` out clog2(STACK_DEPTH)+1: number of valid return-stack entries
- `stack_overflow` out 1: sticky; set by a `call` while the stack is full
- `stack_underflow` out 1: sticky; set by a `ret` while the stack is empty

## Operation
- Next-PC priority, highest first: reset, `stall`, `ret`, `call`, `jump`, `branch_taken`, increment (PC+1).
- Only the highest-priority asserted control acts. Lower ones are ignored in that cycle, with no side effects.
- All address arithmetic is modulo 2^ADDR_WIDTH:
  - 1023+1 → 0.
  - 5 + (−8) → 1021.
  - Branch offset is sign-extended to ADDR_WIDTH before the add.
- `call`, stack not full: push PC+1 (wrapped), depth+1, PC ← `jump_addr`.
- `call`, stack full:
  - PC ← `jump_addr`.
  - No push; stack contents and depth are unchanged (oldest entries preserved).
  - `stack_overflow` ← 1.
- `ret`, stack not empty: PC ← top entry, depth−1.
- `ret`, stack empty: PC ← PC+1, depth stays 0, `stack_underflow` ← 1.
- `stall`: PC, stack, depth and flags all hold. No push or pop occurs even if `call`/`ret` is asserted.
- Error flags clear only on reset. They do not otherwise affect operation.

## Timing
- Reset (asynchronous, immediate on assertion), all outputs:
  - `instruction_addr_pc` = 0
  - `stack_depth` = 0
  - `stack_overflow` = 0
  - `stack_underflow` = 0
- Reset also clears the stack storage.
- First increment occurs on the first rising edge with `reset_pc` low and `stall` low.
- Latency: controls are sampled on rising edge N. The new address is visible after edge N; the instruction memory consumes it on edge N+1.
- Reset asserted mid-call or mid-ret: all state is discarded; no partial push or pop survives.
- Back-to-back `call` then `ret`: return address is available the next cycle (no bypass hazard; stack write and read are on separate edges).
- Simultaneous `call` and `ret`: `ret` wins. Pop only; `jump_addr` is ignored.
- Full/empty boundaries:
  - depth = STACK_DEPTH blocks push.
  - depth = 0 blocks pop.
  - Flags set on the same edge as the offending request.

## Structure
- Shared package `cpu_pkg`:
  - `ADDR_WIDTH`=10
  - `INSTR_WIDTH`=12
  - Reset address constant `RESET_PC`=0
  - Next-PC source enum (`PC_HOLD`, `PC_INC`, `PC_BRANCH`, `PC_JUMP`, `PC_CALL`, `PC_RET`)
- The top level contains:
  - A combinational priority selector producing the enum.
  - The PC register.
  - The flag registers.
- Sub-module `return_stack`: STACK_DEPTH×ADDR_WIDTH LIFO with `push`, `pop`, `push_data`, `top`, `depth`, `full`, `empty`, and asynchronous reset. It performs no overflow/underflow handling itself; the top level gates push and pop.

## Test plan
- Reset then 4 free-running cycles → `instruction_addr_pc` 0,1,2,3,4. Assert `reset_pc` mid-cycle at PC=4 → PC 0 immediately, depth 0, flags 0.
- Wrap and branch:
  - `jump` to 1022, then run → 1023, 0.
  - At PC=5, `branch_taken` with offset 0xF8 (−8) → 1021.
  - At PC=10, offset 0x7F → 137.
- At PC=3, `call` to 100 → PC 100, depth 1. At PC=101, `ret` → PC 4, depth 0.
- Five calls from PCs 0,10,20,30,40 to 10,20,30,40,50 (depth 4):
  - Fifth call → PC 50, depth 4, `stack_overflow`=1.
  - Four rets → 31,21,11,1.
  - Fifth ret → PC 2, `stack_underflow`=1.
- Stall and priority:
  - `stall` with `call`/`jump` asserted at PC=7 for 3 cycles → PC stays 7, depth unchanged.
  - Then assert `ret`+`call`+`jump` together with depth 1 → `ret` taken, `jump_addr` ignored.
